// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction width, NOP word, address type and loader states
package cpu_pkg;

    localparam int IW    = 9;
    localparam int DEPTH = 256;

    localparam logic [IW-1:0] NOP = 9'h000;

    typedef logic [7:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        HALTED
    } ldr_state_t;

endpackage

// File: rtl/imem_store.sv
// rtl/imem_store.sv - 256-entry instruction store, sync write port and async read port
import cpu_pkg::*;

module imem_store (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    waddr,
    input  logic [IW-1:0] wdata,
    input  logic [7:0]    raddr,
    output logic [IW-1:0] rdata
);

    // Contents are deliberately never cleared so a halted program stays inspectable.
    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program loader and instruction responder for the fetch stage
import cpu_pkg::*;

module imem_loader (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [7:0]    load_len,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    output logic          load_ready,
    input  logic [7:0]    pc,
    output logic [IW-1:0] instr,
    input  logic          halt_req,
    output logic          core_reset,
    output logic          core_halt,
    output logic          busy,
    output logic          done,
    output logic [15:0]   cycles
);

    ldr_state_t    state_q, state_d;
    logic [8:0]    len_q, len_d;
    logic [8:0]    cnt_q, cnt_d;
    addr_t         wptr_q, wptr_d;
    logic [15:0]   cycles_q, cycles_d;
    logic          load_ready_q, load_ready_d;
    logic          core_reset_q, core_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          run_q, run_d;

    logic          accept;
    logic          start_load;
    logic [IW-1:0] rdata;

    // load_ready_q is only ever high in LOAD, so accept implies LOAD.
    assign accept = load_valid & load_ready_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        cycles_d   = cycles_q;
        start_load = 1'b0;

        case (state_q)
            IDLE: begin
                start_load = load_start;
            end
            LOAD: begin
                if (accept) begin
                    wptr_d = wptr_q + 8'd1;
                    cnt_d  = cnt_q + 9'd1;
                    if (cnt_q + 9'd1 == len_q) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                if (cycles_q != 16'hFFFF) begin
                    cycles_d = cycles_q + 16'd1;
                end
                if (halt_req) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                start_load = load_start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_load) begin
            state_d  = LOAD;
            len_d    = (load_len == 8'd0) ? 9'd256 : {1'b0, load_len};
            cnt_d    = 9'd0;
            wptr_d   = 8'd0;
            cycles_d = 16'd0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        load_ready_d = 1'b0;
        core_reset_d = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        run_d        = 1'b0;
        case (state_d)
            LOAD: begin
                load_ready_d = 1'b1;
                busy_d       = 1'b1;
            end
            START: begin
                busy_d = 1'b1;
            end
            RUN: begin
                core_reset_d = 1'b0;
                busy_d       = 1'b1;
                run_d        = 1'b1;
            end
            HALTED: begin
                core_reset_d = 1'b0;
                done_d       = 1'b1;
            end
            default: begin
                core_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= 9'd0;
            cnt_q        <= 9'd0;
            wptr_q       <= 8'd0;
            cycles_q     <= 16'd0;
            load_ready_q <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            cycles_q     <= cycles_d;
            load_ready_q <= load_ready_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            run_q        <= run_d;
        end
    end

    imem_store u_store (
        .clk   (clk),
        .we    (accept & ~reset),
        .waddr (wptr_q),
        .wdata (load_data),
        .raddr (pc),
        .rdata (rdata)
    );

    // Zero-latency fetch and halt so the single-cycle core never steps past a halt.
    assign instr      = run_q ? rdata : NOP;
    assign core_halt  = run_q ? halt_req : 1'b1;
    assign load_ready = load_ready_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  load_len = 8'd0;
    logic        load_valid = 1'b0;
    logic [8:0]  load_data = 9'd0;
    logic        load_ready;
    logic [7:0]  pc = 8'd0;
    logic [8:0]  instr;
    logic        halt_req = 1'b0;
    logic        core_reset;
    logic        core_halt;
    logic        busy;
    logic        done;
    logic [15:0] cycles;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .pc         (pc),
        .instr      (instr),
        .halt_req   (halt_req),
        .core_reset (core_reset),
        .core_halt  (core_halt),
        .busy       (busy),
        .done       (done),
        .cycles     (cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset got %b want 1", core_reset); end
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL rst_core_halt got %b want 1", core_halt); end
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_load_ready got %b want 0", load_ready); end
        n_cmp++; if (instr !== 9'h000) begin n_fail++; $display("FAIL rst_instr got %h want 000", instr); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (cycles !== 16'd0) begin n_fail++; $display("FAIL rst_cycles got %0d want 0", cycles); end
    endtask

    task automatic test_load3();
        logic [8:0] words [3];
        words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h1FF;
        load_len = 8'd3;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL l3_busy got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data = words[i];
            n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL l3_ready[%0d] got %b want 1", i, load_ready); end
            step();
        end
        load_valid = 1'b0;
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL l3_ready_after got %b want 0", load_ready); end
        n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL l3_start_core_reset got %b want 1", core_reset); end
        n_cmp++; if (instr !== 9'h000) begin n_fail++; $display("FAIL l3_start_instr got %h want 000", instr); end
        step();
        n_cmp++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL l3_run_core_reset got %b want 0", core_reset); end
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL l3_run_core_halt got %b want 0", core_halt); end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i);
            #1;
            n_cmp++; if (instr !== words[i]) begin n_fail++; $display("FAIL l3_instr[%0d] got %h want %h", i, instr, words[i]); end
        end
    endtask

    task automatic test_halt();
        repeat (5) step();
        pc = 8'd2;
        halt_req = 1'b1;
        #1;
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL halt_core_halt_comb got %b want 1", core_halt); end
        n_cmp++; if (cycles !== 16'd5) begin n_fail++; $display("FAIL halt_cycles_pre got %0d want 5", cycles); end
        step();
        halt_req = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy got %b want 0", busy); end
        n_cmp++; if (cycles !== 16'd6) begin n_fail++; $display("FAIL halt_cycles got %0d want 6", cycles); end
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL halt_core_halt got %b want 1", core_halt); end
        n_cmp++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL halt_core_reset got %b want 0", core_reset); end
        n_cmp++; if (instr !== 9'h000) begin n_fail++; $display("FAIL halt_instr got %h want 000", instr); end
    endtask

    task automatic test_toggle_load4();
        logic [8:0] words [4];
        logic [6:0] pat;
        int k;
        words[0] = 9'h101; words[1] = 9'h102; words[2] = 9'h103; words[3] = 9'h104;
        pat = 7'b1010101;
        k = 0;
        load_len = 8'd4;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL t4_done_cleared got %b want 0", done); end
        n_cmp++; if (cycles !== 16'd0) begin n_fail++; $display("FAIL t4_cycles_cleared got %0d want 0", cycles); end
        for (int j = 0; j < 7; j++) begin
            load_valid = pat[6-j];
            load_data = pat[6-j] ? words[k] : 9'h1AA;
            load_start = (j == 2);
            load_len = (j == 2) ? 8'd1 : 8'd4;
            n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready[%0d] got %b want 1", j, load_ready); end
            step();
            if (pat[6-j]) k++;
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL t4_ready_after got %b want 0", load_ready); end
        n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL t4_start_core_reset got %b want 1", core_reset); end
        step();
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            #1;
            n_cmp++; if (instr !== words[i]) begin n_fail++; $display("FAIL t4_instr[%0d] got %h want %h", i, instr, words[i]); end
        end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        n_cmp++; if (cycles !== 16'd1) begin n_fail++; $display("FAIL t4_cycles got %0d want 1", cycles); end
    endtask

    task automatic test_len0();
        load_len = 8'd0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1;
            load_data = 9'(i * 3 + 5);
            if (i == 255) begin
                n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL l0_ready_last got %b want 1", load_ready); end
            end
            step();
        end
        load_valid = 1'b0;
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL l0_ready_after got %b want 0", load_ready); end
        step();
        pc = 8'hFF; #1;
        n_cmp++; if (instr !== 9'h102) begin n_fail++; $display("FAIL l0_instr_ff got %h want 102", instr); end
        pc = 8'h80; #1;
        n_cmp++; if (instr !== 9'h185) begin n_fail++; $display("FAIL l0_instr_80 got %h want 185", instr); end
        pc = 8'h00; #1;
        n_cmp++; if (instr !== 9'h005) begin n_fail++; $display("FAIL l0_instr_00 got %h want 005", instr); end
        halt_req = 1'b1;
        load_start = 1'b1;
        load_len = 8'd2;
        step();
        halt_req = 1'b0;
        load_start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL l0_halt_wins_done got %b want 1", done); end
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL l0_halt_wins_ready got %b want 0", load_ready); end
    endtask

    task automatic test_reset_mid_load();
        load_len = 8'd5;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 9'h0AA;
        step();
        load_data = 9'h0BB;
        step();
        load_data = 9'h0CC;
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_valid = 1'b0;
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready got %b want 0", load_ready); end
        n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rm_core_reset got %b want 1", core_reset); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rm_done got %b want 0", done); end
        load_len = 8'd1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 9'h123;
        step();
        load_valid = 1'b0;
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_after got %b want 0", load_ready); end
        step();
        pc = 8'd0; #1;
        n_cmp++; if (instr !== 9'h123) begin n_fail++; $display("FAIL rm_instr0 got %h want 123", instr); end
        pc = 8'd1; #1;
        n_cmp++; if (instr !== 9'h0BB) begin n_fail++; $display("FAIL rm_instr1 got %h want 0bb", instr); end
        pc = 8'd2; #1;
        n_cmp++; if (instr !== 9'h00B) begin n_fail++; $display("FAIL rm_instr2 got %h want 00b", instr); end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rm_done_end got %b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_load3();
        test_halt();
        test_toggle_load4();
        test_len0();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory responder and program loader on the far side of the fetch stage's 8-bit PC.
- A host streams a program into an internal 256-entry instruction store over a valid/ready port while the core is held in reset.
- The block then releases the core and answers each PC with its instruction word.
- It watches for the decoder's halt request, then freezes the core and reports completion plus a run-cycle count.

Parameters:
- IW, 9, instruction word width.
- DEPTH, 256, instruction store entries; equals 2^8, the PC width.
- NOP, 9'h000, word driven on instr whenever the store is not being served.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- load_start  input  1  pulse; begins a program load.
- load_len  input  8  word count, sampled on load_start; 0 means 256.
- load_valid  input  1  host word valid.
- load_data  input  IW  host word.
- load_ready  output  1  block accepts a word this cycle.
- pc  input  8  fetch address from the fetch stage.
- instr  output  IW  instruction at pc.
- halt_req  input  1  decoder has decoded a halt instruction.
- core_reset  output  1  drives the fetch stage reset.
- core_halt  output  1  drives the fetch stage halt.
- busy  output  1  load or run in progress.
- done  output  1  program has halted.
- cycles  output  16  RUN cycles executed by the last program, saturating.

Behaviour:
- States: IDLE, LOAD, START, RUN, HALTED. Reset forces IDLE.
- Reset values: load_ready=0, core_reset=1, core_halt=1, busy=0, done=0, cycles=0, write pointer=0. The store contents are not cleared.
- IDLE:
  - core_reset=1.
  - load_start -> LOAD; latch len (0 -> 256); wptr=0; clear cycles and done.
- LOAD:
  - load_ready=1, busy=1, core_reset=1.
  - A word is accepted when load_valid & load_ready. It is written to mem[wptr] on the same edge and wptr increments, wrapping 255->0.
  - After the len-th accept -> START. load_ready is 0 from the next cycle on.
  - load_valid with no accept is ignored.
  - load_start while in LOAD is ignored.
- START:
  - Exactly one cycle; core_reset=1, so the PC is zeroed on this edge. Then -> RUN.
- RUN:
  - core_reset=0, busy=1.
  - instr = mem[pc], combinational (zero latency), so the single-cycle core fetches and decodes in the same cycle.
  - core_halt = halt_req, combinational, so the PC does not advance past the halt instruction.
  - cycles increments each RUN cycle and saturates at 16'hFFFF.
  - halt_req -> HALTED next edge. The halt cycle is counted.
- HALTED:
  - core_halt=1, core_reset=0. PC holds, so the core state stays observable.
  - done=1, busy=0.
  - load_start -> LOAD (same actions as in IDLE).
- instr = NOP in every state except RUN.
- A PC beyond the loaded length returns stale store contents. This is not an error.
- Reset mid-LOAD or mid-RUN: IDLE on the next edge. Words already written stay in the store; the partial load is abandoned.
- load_start and halt_req in the same RUN cycle: halt wins; load_start is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - IW.
  - NOP.
  - the 8-bit address type addr_t.
  - the state enum ldr_state_t (IDLE, LOAD, START, RUN, HALTED).
- One natural sub-module: imem_store. It is a 256xIW array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- The FSM, counters and handshake stay in imem_loader.

Test Plan:
- Reset, then idle 5 cycles -> core_reset=1, core_halt=1, load_ready=0, instr=9'h000, done=0.
- load_start with load_len=3; host sends 9'h011, 9'h022, 9'h1FF with valid held high -> three accepts on consecutive cycles; load_ready low after the 3rd; one START cycle with core_reset=1; then RUN; pc=0,1,2 returns 011, 022, 1FF.
- Load of len 4 with load_valid toggled 1,0,1,0,1,0,1 -> exactly 4 writes, to addresses 0..3 in order; START entered only after the 4th accept.
- RUN with halt_req raised on the 6th RUN cycle -> core_halt high in that same cycle; HALTED next edge; done=1, busy=0, cycles=6; PC frozen.
- load_len=0 -> 256 accepts, wptr wraps to 0, then START; pc=8'hFF returns the 256th word.
- Reset asserted mid-LOAD after 2 of 5 words -> IDLE next edge, load_ready=0, core_reset=1; a new load_start restarts at wptr=0.
